// File: rtl/pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_generator
//  Description : Free-running eight-beat one-hot timing pulse generator
//                (T0..T7) with an optional per-beat clock prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_generator #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic T0,
    output logic T1,
    output logic T2,
    output logic T3,
    output logic T4,
    output logic T5,
    output logic T6,
    output logic T7
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [7:0] r_beat_q;
    logic [7:0] w_beat_d;
    logic       w_adv;
    logic       w_one_hot;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

            logic [c_CNT_W-1:0] r_cnt_q;
            logic [c_CNT_W-1:0] w_cnt_d;

            // Out-of-range counts behave as the terminal count and roll over.
            always_comb begin
                w_adv   = (r_cnt_q >= c_CNT_MAX);
                w_cnt_d = w_adv ? '0 : r_cnt_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt_q <= '0;
                end else begin
                    r_cnt_q <= w_cnt_d;
                end
            end
        end else begin : g_nodiv
            assign w_adv = 1'b1;
        end
    endgenerate

    assign w_one_hot = (r_beat_q != 8'h00) && ((r_beat_q & (r_beat_q - 8'd1)) == 8'h00);

    // A corrupted ring is reloaded with T0 on the next advance instead of rotating.
    always_comb begin
        w_beat_d = r_beat_q;
        if (w_adv) begin
            w_beat_d = w_one_hot ? {r_beat_q[6:0], r_beat_q[7]} : 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_q <= 8'h01;
        end else begin
            r_beat_q <= w_beat_d;
        end
    end

    assign T0 = r_beat_q[0];
    assign T1 = r_beat_q[1];
    assign T2 = r_beat_q[2];
    assign T3 = r_beat_q[3];
    assign T4 = r_beat_q[4];
    assign T5 = r_beat_q[5];
    assign T6 = r_beat_q[6];
    assign T7 = r_beat_q[7];

endmodule
`default_nettype wire

// File: tb/tb_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_generator
//  Description : Scoreboard bench for pulse_generator, CLK_DIV=1 and CLK_DIV=3.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pulse_generator;

    logic       clk   = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [7:0] t_a;
    logic [7:0] t_b;

    pulse_generator #(.CLK_DIV(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .T0(t_a[0]), .T1(t_a[1]), .T2(t_a[2]), .T3(t_a[3]),
        .T4(t_a[4]), .T5(t_a[5]), .T6(t_a[6]), .T7(t_a[7])
    );

    pulse_generator #(.CLK_DIV(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .T0(t_b[0]), .T1(t_b[1]), .T2(t_b[2]), .T3(t_b[3]),
        .T4(t_b[4]), .T5(t_b[5]), .T6(t_b[6]), .T7(t_b[7])
    );

    always #5 clk = ~clk;

    // Reference model: current beat number (-1 = corrupted ring) and clocks spent in it.
    int         m_idx[2];
    int         m_ph[2];
    logic [7:0] m_bad[2];
    bit         m_live[2];
    int         c_div[2] = '{1, 3};

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] f_val_a;
    logic [7:0] f_val_b;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int idx_of(input logic [7:0] v);
        return ($countones(v) == 1) ? $clog2(v) : -1;
    endfunction

    function automatic logic [7:0] model_step(input int k, input bit r);
        logic [7:0] one;
        if (r) begin
            m_idx[k]  = 0;
            m_ph[k]   = 0;
            m_live[k] = 1'b1;
        end else if (m_ph[k] >= c_div[k] - 1) begin
            m_ph[k]  = 0;
            m_idx[k] = (m_idx[k] < 0) ? 0 : (m_idx[k] + 1) % 8;
        end else begin
            m_ph[k] = m_ph[k] + 1;
        end
        one = 8'h01;
        return (m_idx[k] < 0) ? m_bad[k] : (one << m_idx[k]);
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    // One clock of stimulus: optional ring corruption, then reset levels for the next edge.
    task automatic cyc(input bit ra, input bit rb,
                       input bit fa = 1'b0, input logic [7:0] va = 8'h00,
                       input bit fb = 1'b0, input logic [7:0] vb = 8'h00);
        logic [7:0] e;
        @(negedge clk);
        rst_a = ra;
        rst_b = rb;
        if (fa) begin
            f_val_a = va;
            force dut_a.r_beat_q = f_val_a;
            #1;
            release dut_a.r_beat_q;
            m_idx[0] = idx_of(va);
            m_bad[0] = va;
        end
        if (fb) begin
            f_val_b = vb;
            force dut_b.r_beat_q = f_val_b;
            #1;
            release dut_b.r_beat_q;
            m_idx[1] = idx_of(vb);
            m_bad[1] = vb;
        end
        e = model_step(0, ra);
        if (m_live[0]) q_a.push_back(e);
        e = model_step(1, rb);
        if (m_live[1]) q_b.push_back(e);
        @(posedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q_a.size() > 0) check("beat_div1", t_a, q_a.pop_front());
        if (q_b.size() > 0) check("beat_div3", t_b, q_b.pop_front());
    end

    initial begin
        bit         ra, rb, fa, fb;
        logic [7:0] va, vb;

        cyc(1, 1);
        cyc(1, 1);
        repeat (30) cyc(0, 0);

        for (int i = 0; i < 16 && m_idx[0] != 5; i++) cyc(0, 0);
        cyc(1, 0);
        repeat (3) cyc(0, 0);

        for (int i = 0; i < 48 && !(m_idx[1] == 7 && m_ph[1] == 2); i++) cyc(0, 0);
        cyc(0, 1);
        repeat (4) cyc(0, 0);

        for (int i = 0; i < 16 && m_idx[0] != 7; i++) cyc(0, 0);
        cyc(1, 0);
        cyc(0, 0);

        cyc(0, 0, 1'b1, 8'h00, 1'b1, 8'h00);
        repeat (6) cyc(0, 0);
        cyc(0, 0, 1'b1, 8'h24, 1'b1, 8'h24);
        repeat (6) cyc(0, 0);

        repeat (300) begin
            ra = ($urandom_range(15) == 0);
            rb = ($urandom_range(15) == 0);
            fa = ($urandom_range(31) == 0);
            fb = ($urandom_range(31) == 0);
            va = 8'($urandom);
            vb = 8'($urandom);
            cyc(ra, rb, fa, va, fb, vb);
        end
        cyc(0, 0);

        @(posedge clk);
        #3;
        n_chk++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Eight-beat timing-pulse generator for the CPU model's control unit.
- Produces one-hot beat signals T0..T7 that step the micro-operation sequence: exactly one beat is high at a time, rotating T0→T7→T0.
- Purely free-running after reset; no other inputs.
- Outputs are registered and glitch-free, so they can feed control logic directly.

Parameters:
- CLK_DIV, 1, clock cycles each beat is held (≥1). A value of 1 advances one beat per clock.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- T0  output  1  beat 0 (high while beat 0 is active).
- T1  output  1  beat 1.
- T2  output  1  beat 2.
- T3  output  1  beat 3.
- T4  output  1  beat 4.
- T5  output  1  beat 5.
- T6  output  1  beat 6.
- T7  output  1  beat 7.
- Port order is fixed exactly as listed (clk, rst, T0..T7); instances connect positionally.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- State:
  - 8-bit one-hot ring register beat[7:0]; Tn = beat[n], driven straight from flops.
  - Prescaler count div_cnt of width clog2(CLK_DIV), minimum 1 bit.
- Reset: on a rising edge with rst=1, beat = 8'b0000_0001 (T0=1, T1..T7=0) and div_cnt = 0. Reset has priority over everything else.
- Held reset: T0 stays high and the others stay low for as long as rst=1.
- Advance with CLK_DIV=1: each rising edge with rst=0 rotates beat left by one. T7→T0 wraps, giving period 8 clocks.
- Advance with CLK_DIV>1:
  - div_cnt increments each clock.
  - When div_cnt = CLK_DIV-1, div_cnt returns to 0 and beat rotates.
  - Each beat is held for CLK_DIV clocks; period is 8·CLK_DIV clocks.
- Latency:
  - The first rising edge after rst falls is the first advance edge (CLK_DIV=1). T1 goes high on that edge.
  - With CLK_DIV>1, T1 goes high CLK_DIV edges after rst falls.
- Invariant: after any reset, exactly one of T0..T7 is high on every cycle.
- Illegal-state recovery:
  - If beat is not one-hot (all-zero or more than one bit set, e.g. after power-up without reset or an SEU), the next advance edge loads 8'b0000_0001 instead of rotating.
  - div_cnt values ≥ CLK_DIV are treated as CLK_DIV-1, so the next edge rolls over.
- Before the first reset, outputs are X in simulation. No initial blocks in the synthesizable RTL.
- Reset mid-sequence (any beat, any div_cnt): the next edge returns to T0 with div_cnt=0. No partial beat is emitted.

Test Plan:
1. Hold rst=1 for 2 edges, then release (CLK_DIV=1) → T0=1 during reset. Then T1, T2 … T7, T0 on successive edges; wrap from T7 to T0 in exactly 1 clock; period is 8 clocks.
2. One-hot check across 100 clocks after reset → popcount{T7..T0}=1 on every cycle.
3. Assert rst for one edge while T5 is high → next cycle T0=1 and all others 0; the sequence resumes T1 on the following edge.
4. Instance with CLK_DIV=3 → each Tn is high for exactly 3 clocks; T0 rises again 24 clocks after its first rise.
5. Force the beat register to 8'b0000_0000, then to 8'b0010_0100, with rst=0 → next advance edge gives T0=1 only, and normal rotation follows.
6. Apply rst=1 coincident with an advance edge at T7 → T0 is loaded; there is no extra rotation to T1.
